// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared types and constants for the SAR sequencer
//
// Purpose: state encoding, default build parameters and the conversion
// latency helper used by sar_seq and sar_wait_cnt.
// Ports: none (package).

package sar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETTLE,
    ST_STROBE,
    ST_CAPTURE,
    ST_DONE
  } sar_state_e;

  localparam int SAR_NBITS   = 8;
  localparam int SAR_SETTLE  = 2;
  localparam int SAR_CAP_LAT = 2;

  // Edges from the VSTART sample edge (counted as the first) up to and
  // including the edge that raises VDONE.
  function automatic int sar_latency(input int nbits, input int settle, input int cap_lat);
    return 2 + nbits * (settle + 1 + cap_lat);
  endfunction

  localparam int SAR_LATENCY = sar_latency(SAR_NBITS, SAR_SETTLE, SAR_CAP_LAT);

endpackage

// File: rtl/sar_wait_cnt.sv
// rtl/sar_wait_cnt.sv - loadable down-counter with zero flag
//
// Purpose: times the SETTLE and CAPTURE phases of the sequencer.
// Ports:
//   clk       in  clock
//   rst_n     in  asynchronous active-low reset
//   load      in  load load_val (takes priority over dec)
//   load_val  in  value to load
//   dec       in  decrement by one, saturating at zero
//   zero      out counter currently holds zero

module sar_wait_cnt
  import sar_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sar_seq.sv
// rtl/sar_seq.sv - successive-approximation sequencer for the slice array
//
// Purpose: clears the comparator slices, then for each bit MSB..LSB presents
// a trial DAC code, strobes the slice enable, waits for the slice's BITOUT
// and folds it into the result. Pulses VDONE with the final code on DOUT.
// Ports:
//   CLK           in  clock, rising edge
//   VRESET_N      in  asynchronous active-low reset
//   VSTART        in  start request, honoured in IDLE only
//   VABORT        in  abort a conversion in progress (while VBUSY)
//   BITS          in  per-slice BITOUT, BITS[i] from slice i
//   VENABLE       out one-hot per-slice enable strobe
//   VSLICE_RESET  out active-high reset to all slices
//   DAC_CODE      out trial code to the DAC
//   DOUT          out last completed result
//   VBUSY         out conversion in progress
//   VDONE         out one-cycle pulse, DOUT valid

module sar_seq
  import sar_pkg::*;
#(
  parameter int NBITS   = SAR_NBITS,
  parameter int SETTLE  = SAR_SETTLE,
  parameter int CAP_LAT = SAR_CAP_LAT
) (
  input  logic             CLK,
  input  logic             VRESET_N,
  input  logic             VSTART,
  input  logic             VABORT,
  input  logic [NBITS-1:0] BITS,
  output logic [NBITS-1:0] VENABLE,
  output logic             VSLICE_RESET,
  output logic [NBITS-1:0] DAC_CODE,
  output logic [NBITS-1:0] DOUT,
  output logic             VBUSY,
  output logic             VDONE
);

  localparam int MAX_WAIT = (SETTLE > CAP_LAT) ? SETTLE : CAP_LAT;
  localparam int CW       = $clog2(MAX_WAIT + 1);
  localparam int IW       = $clog2(NBITS);

  localparam logic [NBITS-1:0] ONE       = NBITS'(1);
  localparam logic [IW-1:0]    IDX_MSB   = IW'(NBITS - 1);
  localparam logic [CW-1:0]    SETTLE_LD = CW'(SETTLE - 1);
  localparam logic [CW-1:0]    CAP_LD    = CW'(CAP_LAT - 1);

  sar_state_e       state_q, state_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;
  logic [NBITS-1:0] result_q, result_d;
  logic [NBITS-1:0] venable_q, venable_d;
  logic             vslice_reset_q, vslice_reset_d;
  logic [NBITS-1:0] dac_code_q, dac_code_d;
  logic [NBITS-1:0] dout_q, dout_d;
  logic             vbusy_q, vbusy_d;
  logic             vdone_q, vdone_d;

  logic             cnt_load;
  logic [CW-1:0]    cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [IW-1:0]    next_idx;

  sar_wait_cnt #(
    .W(CW)
  ) u_wait_cnt (
    .clk      (CLK),
    .rst_n    (VRESET_N),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign next_idx = bit_idx_q - IW'(1);

  always_comb begin
    state_d        = state_q;
    bit_idx_d      = bit_idx_q;
    result_d       = result_q;
    venable_d      = '0;
    vslice_reset_d = 1'b0;
    dac_code_d     = dac_code_q;
    dout_d         = dout_q;
    vbusy_d        = vbusy_q;
    vdone_d        = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_val   = '0;
    cnt_dec        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        result_d   = '0;
        bit_idx_d  = IDX_MSB;
        dac_code_d = '0;
        vbusy_d    = 1'b0;
        if (VSTART) begin
          state_d        = ST_CLEAR;
          vslice_reset_d = 1'b1;
          vbusy_d        = 1'b1;
        end
      end

      ST_CLEAR: begin
        state_d      = ST_SETTLE;
        dac_code_d   = result_q | (ONE << bit_idx_q);
        cnt_load     = 1'b1;
        cnt_load_val = SETTLE_LD;
      end

      ST_SETTLE: begin
        if (cnt_zero) begin
          state_d   = ST_STROBE;
          venable_d = ONE << bit_idx_q;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_STROBE: begin
        state_d      = ST_CAPTURE;
        cnt_load     = 1'b1;
        cnt_load_val = CAP_LD;
      end

      ST_CAPTURE: begin
        if (cnt_zero) begin
          // BITS is only trusted on the last CAPTURE edge; earlier edges may
          // still see the slice's previous BITOUT.
          result_d[bit_idx_q] = BITS[bit_idx_q];
          if (bit_idx_q != '0) begin
            state_d      = ST_SETTLE;
            bit_idx_d    = next_idx;
            dac_code_d   = result_d | (ONE << next_idx);
            cnt_load     = 1'b1;
            cnt_load_val = SETTLE_LD;
          end else begin
            state_d    = ST_DONE;
            dout_d     = result_d;
            dac_code_d = '0;
            vbusy_d    = 1'b0;
            vdone_d    = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_DONE: begin
        // VSTART here is deliberately ignored; it must be seen in IDLE.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort only matters while busy; it also wins over the final capture.
    if (VABORT && vbusy_q) begin
      state_d        = ST_IDLE;
      bit_idx_d      = IDX_MSB;
      result_d       = '0;
      venable_d      = '0;
      vslice_reset_d = 1'b1;
      dac_code_d     = '0;
      dout_d         = dout_q;
      vbusy_d        = 1'b0;
      vdone_d        = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge VRESET_N) begin
    if (!VRESET_N) begin
      state_q        <= ST_IDLE;
      bit_idx_q      <= IDX_MSB;
      result_q       <= '0;
      venable_q      <= '0;
      vslice_reset_q <= 1'b1;
      dac_code_q     <= '0;
      dout_q         <= '0;
      vbusy_q        <= 1'b0;
      vdone_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_idx_q      <= bit_idx_d;
      result_q       <= result_d;
      venable_q      <= venable_d;
      vslice_reset_q <= vslice_reset_d;
      dac_code_q     <= dac_code_d;
      dout_q         <= dout_d;
      vbusy_q        <= vbusy_d;
      vdone_q        <= vdone_d;
    end
  end

  assign VENABLE      = venable_q;
  assign VSLICE_RESET = vslice_reset_q;
  assign DAC_CODE     = dac_code_q;
  assign DOUT         = dout_q;
  assign VBUSY        = vbusy_q;
  assign VDONE        = vdone_q;

endmodule

// File: tb/tb_sar_seq.sv
// tb/tb_sar_seq.sv - directed self-checking bench for sar_seq

module tb_sar_seq;

  logic       CLK = 1'b0;
  logic       VRESET_N;
  logic       VSTART, VABORT;
  logic [7:0] BITS, VENABLE, DAC_CODE, DOUT;
  logic       VSLICE_RESET, VBUSY, VDONE;

  logic       VSTART2;
  logic       VABORT2;
  logic [7:0] BITS2, VENABLE2, DAC_CODE2, DOUT2;
  logic       VSLICE_RESET2, VBUSY2, VDONE2;

  logic [7:0] v1 = 8'h00;
  logic [7:0] v2 = 8'h00;
  logic [7:0] st1, bo1, st2, bo2;
  logic [1:0] gcnt = 2'd0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  sar_seq dut (
    .CLK          (CLK),
    .VRESET_N     (VRESET_N),
    .VSTART       (VSTART),
    .VABORT       (VABORT),
    .BITS         (BITS),
    .VENABLE      (VENABLE),
    .VSLICE_RESET (VSLICE_RESET),
    .DAC_CODE     (DAC_CODE),
    .DOUT         (DOUT),
    .VBUSY        (VBUSY),
    .VDONE        (VDONE)
  );

  sar_seq #(
    .NBITS   (8),
    .SETTLE  (1),
    .CAP_LAT (3)
  ) dut2 (
    .CLK          (CLK),
    .VRESET_N     (VRESET_N),
    .VSTART       (VSTART2),
    .VABORT       (VABORT2),
    .BITS         (BITS2),
    .VENABLE      (VENABLE2),
    .VSLICE_RESET (VSLICE_RESET2),
    .DAC_CODE     (DAC_CODE2),
    .DOUT         (DOUT2),
    .VBUSY        (VBUSY2),
    .VDONE        (VDONE2)
  );

  // Slice models: the enable edge latches the compare, the next edge moves
  // it to BITOUT.
  always @(posedge CLK) begin
    if (VSLICE_RESET) begin
      st1 <= '0;
      bo1 <= '0;
    end else begin
      for (int i = 0; i < 8; i++)
        if (VENABLE[i]) st1[i] <= (v1 >= DAC_CODE);
      bo1 <= st1;
    end
  end

  always @(posedge CLK) begin
    if (VSLICE_RESET2) begin
      st2 <= '0;
      bo2 <= '0;
    end else begin
      for (int i = 0; i < 8; i++)
        if (VENABLE2[i]) st2[i] <= (v2 >= DAC_CODE2);
      bo2 <= st2;
    end
  end

  // Invert BITS2 for the first two CAPTURE cycles after each strobe.
  always @(posedge CLK) begin
    if (VENABLE2 != 8'h00) gcnt <= 2'd2;
    else if (gcnt != 2'd0) gcnt <= gcnt - 2'd1;
  end

  assign BITS  = bo1;
  assign BITS2 = bo2 ^ ((gcnt != 2'd0) ? 8'hFF : 8'h00);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One conversion on dut; cycle k=1 is the CLEAR cycle after the sample edge.
  task automatic convert(input logic [7:0] v, input bit hold, input bit start_abort,
                         input logic [63:0] exp_dac);
    logic [63:0] strobes;
    logic [63:0] dacs;
    int          done_cnt;
    int          done_k;
    logic        busy43;
    strobes  = '0;
    dacs     = '0;
    done_cnt = 0;
    done_k   = -1;
    busy43   = 1'bx;
    v1       = v;
    @(negedge CLK);
    VSTART = 1'b1;
    VABORT = start_abort;
    @(posedge CLK);
    @(negedge CLK);
    VSTART = hold;
    VABORT = 1'b0;
    check("clear_busy", VBUSY, 1);
    check("clear_slice_reset", VSLICE_RESET, 1);
    for (int k = 1; k <= 43; k++) begin
      if (VENABLE != 8'h00) begin
        strobes = {strobes[55:0], VENABLE};
        dacs    = {dacs[55:0], DAC_CODE};
      end
      if (VDONE) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (k == 2) check("settle_slice_reset", VSLICE_RESET, 0);
      if (k == 43) busy43 = VBUSY;
      @(negedge CLK);
    end
    check("dout", DOUT, v);
    check("done_latency", done_k, 42);
    check("done_count", done_cnt, 1);
    check("strobe_order", strobes, 64'h8040201008040201);
    check("dac_trials", dacs, exp_dac);
    check("idle_after_done", busy43, 0);
    check("restart_after_idle", VBUSY, hold);
    VSTART = 1'b0;
    if (hold) begin
      repeat (50) @(negedge CLK);
      check("held_second_done", VBUSY, 0);
    end
  endtask

  initial begin
    int t;
    int dk;
    int dcnt;
    VRESET_N = 1'b0;
    VSTART   = 1'b0;
    VABORT   = 1'b0;
    VSTART2  = 1'b0;
    VABORT2  = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_venable", VENABLE, 0);
    check("rst_slice_reset", VSLICE_RESET, 1);
    check("rst_dac", DAC_CODE, 0);
    check("rst_dout", DOUT, 0);
    check("rst_busy", VBUSY, 0);
    check("rst_done", VDONE, 0);
    VRESET_N = 1'b1;
    @(negedge CLK);
    check("rst_release_slice_reset", VSLICE_RESET, 0);
    repeat (2) @(negedge CLK);

    convert(8'hFF, 1'b0, 1'b0, 64'h80C0E0F0F8FCFEFF);
    convert(8'h00, 1'b0, 1'b1, 64'h8040201008040201);
    convert(8'h3C, 1'b1, 1'b0, 64'h804020303_83C3E3D);
    convert(8'hA5, 1'b0, 1'b0, 64'h80C0A0B0A8A4A6A5);

    // Abort during bit-4 CAPTURE.
    v1 = 8'hFF;
    @(negedge CLK);
    VSTART = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    VSTART = 1'b0;
    t = 0;
    while (VENABLE != 8'h10 && t < 60) begin
      @(negedge CLK);
      t++;
    end
    check("abort_reach_bit4", VENABLE, 8'h10);
    @(negedge CLK);
    VABORT = 1'b1;
    @(negedge CLK);
    VABORT = 1'b0;
    check("abort_busy", VBUSY, 0);
    check("abort_slice_reset", VSLICE_RESET, 1);
    check("abort_venable", VENABLE, 0);
    check("abort_dac", DAC_CODE, 0);
    check("abort_done", VDONE, 0);
    check("abort_dout", DOUT, 8'hA5);
    @(negedge CLK);
    check("abort_slice_reset_drop", VSLICE_RESET, 0);
    dcnt = 0;
    repeat (50) begin
      if (VDONE) dcnt++;
      @(negedge CLK);
    end
    check("abort_no_done", dcnt, 0);
    check("abort_dout_kept", DOUT, 8'hA5);

    // Asynchronous reset in the middle of SETTLE.
    v1 = 8'h11;
    @(negedge CLK);
    VSTART = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    VSTART = 1'b0;
    @(negedge CLK);
    check("pre_reset_busy", VBUSY, 1);
    #2 VRESET_N = 1'b0;
    #1;
    check("midrst_slice_reset", VSLICE_RESET, 1);
    check("midrst_dout", DOUT, 0);
    check("midrst_busy", VBUSY, 0);
    check("midrst_dac", DAC_CODE, 0);
    check("midrst_venable", VENABLE, 0);
    @(negedge CLK);
    VRESET_N = 1'b1;
    @(negedge CLK);
    check("midrst_release", VSLICE_RESET, 0);
    convert(8'h5A, 1'b0, 1'b0, 64'h804060505_85C5A5B);

    // Second build: SETTLE=1, CAP_LAT=3, with BITS glitched early in CAPTURE.
    v2 = 8'h81;
    @(negedge CLK);
    VSTART2 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    VSTART2 = 1'b0;
    dk = -1;
    for (int k = 1; k <= 60; k++) begin
      if (VDONE2 && dk < 0) dk = k;
      @(negedge CLK);
    end
    check("b2_dout", DOUT2, 8'h81);
    check("b2_done_latency", dk, 42);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
